// File: rtl/tipi_pkg.sv
// tipi_pkg: shared register offsets, RPi register-select codes, FSM states and address helper for the TIPI register bank
package tipi_pkg;
  localparam int OFS_RC = 1;
  localparam int OFS_RD = 3;
  localparam int OFS_TC = 5;
  localparam int OFS_TD = 7;
  localparam logic [1:0] SEL_RD = 2'd0;
  localparam logic [1:0] SEL_RC = 2'd1;
  localparam logic [1:0] SEL_TD = 2'd2;
  localparam logic [1:0] SEL_TC = 2'd3;
  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_COMMIT} rpi_state_e;
  // Channel k's quartet sits 8 bytes below channel k-1's.
  function automatic logic [15:0] reg_addr(input logic [15:0] base, input int ch, input int ofs);
    return base - 16'(8 * ch) + 16'(ofs);
  endfunction
endpackage

// File: rtl/tipi_sync.sv
// tipi_sync: STAGES-deep, W-bit-wide flop synchroniser with asynchronous active-high reset
module tipi_sync #(
  parameter int W      = 1,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  logic [STAGES-1:0][W-1:0] r_ff;
  // Shift every bit independently through the flop chain.
  always_ff @(posedge clk or posedge rst)
    if (rst) r_ff <= '0;
    else     r_ff <= {r_ff[STAGES-2:0], i_d};
  assign o_q = r_ff[STAGES-1];
endmodule

// File: rtl/tipi_regbank.sv
// tipi_regbank: multi-channel TI<->RPi message registers; TIPI_TC_IRQ_EN enables tc_pending flags
module tipi_regbank import tipi_pkg::*; #(
  parameter int          DATA_W      = 8,
  parameter int          NUM_CH      = 1,
  parameter logic [15:0] BASE_ADDR   = 16'h5FF8,
  parameter int          SYNC_STAGES = 2,
  parameter int          RS_W        = ($clog2(4 * NUM_CH) < 2) ? 2 : $clog2(4 * NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [0:15]       ti_a,
  input  logic [DATA_W-1:0] ti_data,
  input  logic              ti_memen,
  input  logic              ti_we,
  input  logic              ti_dbin,
  input  logic              dsr_en,
  output logic [DATA_W-1:0] ti_dout,
  output logic              ti_dout_oe,
  input  logic              rpi_sclk,
  input  logic              rpi_sle,
  input  logic              rpi_sdata_in,
  input  logic [RS_W-1:0]   rpi_regsel,
  output logic              rpi_sdata_out,
  output logic              frame_err,
  output logic [NUM_CH-1:0] tc_pending
);
  localparam int CW = $clog2(DATA_W + 2);
  logic [15:0] w_a;
  logic [DATA_W-1:0] w_data, w_rval, w_td_sel, w_tc_sel;
  logic w_memen, w_we, w_dbin, w_dsr, w_sclk, w_sle, w_sdi;
  logic [RS_W-1:0] w_rs, w_ch;
  logic [1:0] w_code;
  logic w_ch_ok, w_sclk_rise, w_sle_rise, w_cap, w_commit, w_rsel, w_sel, w_shift_en;
  logic w_cm, w_frame_ok, w_load_rd, w_load_rc, w_load_td, w_load_tc, w_bad;
  logic [NUM_CH-1:0] w_tc_wr;
  logic r_we_d, r_sclk_d, r_sle_d, r_wr_pend, r_oe, r_ferr;
  logic [15:0] r_ha;
  logic [DATA_W-1:0] r_hd, r_dout, r_sin, r_sout;
  logic [DATA_W-1:0] r_td [NUM_CH];
  logic [DATA_W-1:0] r_tc [NUM_CH];
  logic [DATA_W-1:0] r_rd [NUM_CH];
  logic [DATA_W-1:0] r_rc [NUM_CH];
  logic [CW-1:0] r_bitcnt;
  rpi_state_e r_state, w_next;

  tipi_sync #(.W(16 + DATA_W + 7 + RS_W), .STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .i_d ({ti_a, ti_data, ti_memen, ti_we, ti_dbin, dsr_en, rpi_sclk, rpi_sle, rpi_sdata_in, rpi_regsel}),
    .o_q ({w_a, w_data, w_memen, w_we, w_dbin, w_dsr, w_sclk, w_sle, w_sdi, w_rs})
  );

  assign w_sclk_rise = w_sclk & ~r_sclk_d;
  assign w_sle_rise  = w_sle & ~r_sle_d;
  assign w_cap       = ~w_we & ~w_memen & w_dsr;
  // A write commits only if the previous clk was still a qualified capture, so dropping dsr_en cancels it.
  assign w_commit    = w_we & ~r_we_d & r_wr_pend;
  assign w_sel       = w_rsel & w_dsr & ~w_memen & w_dbin;
  assign w_ch        = w_rs >> 2;
  assign w_code      = w_rs[1:0];
  assign w_ch_ok     = w_ch < RS_W'(NUM_CH);

  // Edge detectors and the TI write hold registers.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_we_d    <= 1'b0;
      r_sclk_d  <= 1'b0;
      r_sle_d   <= 1'b0;
      r_wr_pend <= 1'b0;
      r_ha      <= '0;
      r_hd      <= '0;
    end else begin
      r_we_d    <= w_we;
      r_sclk_d  <= w_sclk;
      r_sle_d   <= w_sle;
      r_wr_pend <= w_cap;
      if (w_cap) begin
        r_ha <= w_a;
        r_hd <= w_data;
      end
    end

  // Address decode for TI reads, TI TC writes and the RPi read-side channel mux.
  always_comb begin
    w_rsel   = 1'b0;
    w_rval   = '0;
    w_td_sel = '0;
    w_tc_sel = '0;
    w_tc_wr  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (w_a == reg_addr(BASE_ADDR, k, OFS_RC)) begin
        w_rsel = 1'b1;
        w_rval = r_rc[k];
      end
      if (w_a == reg_addr(BASE_ADDR, k, OFS_RD)) begin
        w_rsel = 1'b1;
        w_rval = r_rd[k];
      end
      if (w_ch == RS_W'(k)) begin
        w_td_sel = r_td[k];
        w_tc_sel = r_tc[k];
      end
      w_tc_wr[k] = w_commit & (r_ha == reg_addr(BASE_ADDR, k, OFS_TC));
    end
  end

  // Registered TI read port: data and OE follow the decoded select by one clk.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_oe   <= 1'b1;
      r_dout <= '0;
    end else begin
      r_oe   <= ~w_sel;
      r_dout <= w_sel ? w_rval : '0;
    end

  // TI-owned registers TD and TC.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int k = 0; k < NUM_CH; k++) begin
        r_td[k] <= '0;
        r_tc[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (w_commit && r_ha == reg_addr(BASE_ADDR, k, OFS_TD)) r_td[k] <= r_hd;
        if (w_tc_wr[k]) r_tc[k] <= r_hd;
      end
    end

  // RPi FSM state register.
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;

  // RPi FSM next state; a latch strobe in IDLE goes straight to COMMIT with a zero bit count.
  always_comb begin
    w_next = (r_state == ST_IDLE)  ? (w_sclk_rise ? ST_SHIFT : w_sle_rise ? ST_COMMIT : ST_IDLE) :
             (r_state == ST_SHIFT) ? (w_sle_rise ? ST_COMMIT : ST_SHIFT) : ST_IDLE;
  end

  // RPi FSM outputs: commit-cycle strobes decoded from the register-select code.
  always_comb begin
    w_cm       = (r_state == ST_COMMIT) & w_ch_ok;
    w_frame_ok = r_bitcnt == CW'(DATA_W);
    w_load_rd  = w_cm & (w_code == SEL_RD) & w_frame_ok;
    w_load_rc  = w_cm & (w_code == SEL_RC) & w_frame_ok;
    w_bad      = w_cm & ~w_code[1] & ~w_frame_ok;
    w_load_td  = w_cm & (w_code == SEL_TD);
    w_load_tc  = w_cm & (w_code == SEL_TC);
    w_shift_en = w_sclk_rise & (r_state != ST_COMMIT);
  end

  // RPi shift registers, bit counter, sticky frame error and RPi-owned registers RD and RC.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_sin    <= '0;
      r_sout   <= '0;
      r_bitcnt <= '0;
      r_ferr   <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
        r_rd[k] <= '0;
        r_rc[k] <= '0;
      end
    end else begin
      if (w_shift_en) r_sin <= {r_sin[DATA_W-2:0], w_sdi};
      r_bitcnt <= (r_state == ST_COMMIT) ? '0 :
                  !w_shift_en ? r_bitcnt :
                  (r_state == ST_IDLE) ? CW'(1) :
                  (r_bitcnt == CW'(DATA_W + 1)) ? r_bitcnt : r_bitcnt + CW'(1);
      if (w_bad) r_ferr <= 1'b1;
      r_sout <= w_load_td ? w_td_sel :
                w_load_tc ? w_tc_sel :
                w_sclk_rise ? {r_sout[DATA_W-2:0], 1'b0} : r_sout;
      for (int k = 0; k < NUM_CH; k++) begin
        if (w_ch == RS_W'(k)) begin
          if (w_load_rd) r_rd[k] <= r_sin;
          if (w_load_rc) r_rc[k] <= r_sin;
        end
      end
    end

`ifdef TIPI_TC_IRQ_EN
  logic [NUM_CH-1:0] w_tc_rd, r_tcp;
  // Which channel's TC is being handed to the RPi this clk.
  always_comb begin
    w_tc_rd = '0;
    for (int k = 0; k < NUM_CH; k++) w_tc_rd[k] = w_load_tc & (w_ch == RS_W'(k));
  end
  // Pending flags: a TI commit to TC sets, an RPi TC read clears, set wins a tie.
  always_ff @(posedge clk or posedge rst)
    if (rst) r_tcp <= '0;
    else     r_tcp <= w_tc_wr | (r_tcp & ~w_tc_rd);
  assign tc_pending = r_tcp;
`else
  assign tc_pending = '0;
`endif

  assign ti_dout       = r_dout;
  assign ti_dout_oe    = r_oe;
  assign rpi_sdata_out = r_sout[DATA_W-1];
  assign frame_err     = r_ferr;
endmodule

// File: tb/tb_tipi_regbank.sv
// tb_tipi_regbank: scoreboard bench for tipi_regbank (2 channels, 8-bit); honours TIPI_TC_IRQ_EN
module tb_tipi_regbank;
`ifdef TIPI_TC_IRQ_EN
  localparam logic IRQ = 1'b1;
`else
  localparam logic IRQ = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic [0:15] ti_a = 16'h0;
  logic [7:0] ti_data = 8'h0;
  logic ti_memen = 1'b1, ti_we = 1'b1, ti_dbin = 1'b0, dsr_en = 1'b0;
  logic rpi_sclk = 1'b0, rpi_sle = 1'b0, rpi_sdata_in = 1'b0;
  logic [2:0] rpi_regsel = 3'd0;
  logic [7:0] ti_dout;
  logic ti_dout_oe, rpi_sdata_out, frame_err;
  logic [1:0] tc_pending;
  int n_cmp = 0, n_bad = 0;
  logic [7:0] tq[$];
  logic rq[$];
  logic prev_oe = 1'b1;

  always #5 clk = ~clk;

  tipi_regbank #(.DATA_W(8), .NUM_CH(2), .BASE_ADDR(16'h5FF8), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .ti_a(ti_a), .ti_data(ti_data), .ti_memen(ti_memen), .ti_we(ti_we),
    .ti_dbin(ti_dbin), .dsr_en(dsr_en), .ti_dout(ti_dout), .ti_dout_oe(ti_dout_oe),
    .rpi_sclk(rpi_sclk), .rpi_sle(rpi_sle), .rpi_sdata_in(rpi_sdata_in), .rpi_regsel(rpi_regsel),
    .rpi_sdata_out(rpi_sdata_out), .frame_err(frame_err), .tc_pending(tc_pending)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // TI read monitor: every OE assertion presents one word, checked against the next expectation.
  always @(negedge clk) begin
    if (prev_oe && !ti_dout_oe) begin
      if (tq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL ti_read_unexpected: got %0h expected no read", ti_dout);
      end else chk("ti_read", ti_dout, tq.pop_front());
    end
    prev_oe = ti_dout_oe;
  end

  // RPi monitor: the RPi samples the serial output on each of its clock rises.
  always @(posedge rpi_sclk) if (rq.size() != 0) chk("rpi_bit", rpi_sdata_out, rq.pop_front());

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ti_write(input logic [15:0] a, input logic [7:0] d);
    ti_a = a; ti_data = d; ti_memen = 1'b0; ti_we = 1'b0;
    cyc(6);
    ti_we = 1'b1;
    cyc(6);
    ti_memen = 1'b1;
    cyc(4);
  endtask

  task automatic ti_read(input logic [15:0] a, input logic [7:0] e);
    int i;
    tq.push_back(e);
    ti_a = a; ti_memen = 1'b0; ti_dbin = 1'b1;
    i = 0;
    while (ti_dout_oe && i < 3) begin cyc(1); i++; end
    chk("oe_low_latency", ti_dout_oe, 0);
    cyc(3);
    ti_dbin = 1'b0;
    i = 0;
    while (!ti_dout_oe && i < 3) begin cyc(1); i++; end
    chk("oe_release", ti_dout_oe, 1);
    ti_memen = 1'b1;
    cyc(3);
  endtask

  task automatic sle_pulse();
    rpi_sle = 1'b1; cyc(5); rpi_sle = 1'b0; cyc(5);
  endtask

  task automatic sclk_pulse();
    rpi_sclk = 1'b1; cyc(5); rpi_sclk = 1'b0; cyc(5);
  endtask

  task automatic rpi_write(input logic [2:0] sel, input logic [7:0] d, input int nb);
    rpi_regsel = sel;
    for (int i = nb - 1; i >= 0; i--) begin
      rpi_sdata_in = d[i];
      cyc(2);
      sclk_pulse();
    end
    sle_pulse();
  endtask

  task automatic rpi_read(input logic [2:0] sel, input logic [7:0] e);
    rpi_regsel = sel;
    cyc(2);
    sle_pulse();
    for (int i = 7; i >= 0; i--) rq.push_back(e[i]);
    repeat (8) sclk_pulse();
    sle_pulse();
  endtask

  initial begin
    int lows;
    cyc(3);
    chk("rst_dout", ti_dout, 0);
    chk("rst_oe", ti_dout_oe, 1);
    chk("rst_sdata_out", rpi_sdata_out, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_tc_pending", tc_pending, 0);
    rst = 1'b0;
    dsr_en = 1'b1;
    cyc(5);
    // TI writes TD, RPi reads it back serially MSB first.
    ti_write(16'h5FFF, 8'hA5);
    rpi_read(3'd2, 8'hA5);
    // RPi writes RD, TI reads it.
    rpi_write(3'd0, 8'h3C, 8);
    ti_read(16'h5FFB, 8'h3C);
    // Two channels' TC registers, read back in turn.
    ti_write(16'h5FF5, 8'h11);
    ti_write(16'h5FFD, 8'h22);
    chk("tc_pending_both", tc_pending, IRQ ? 2'b11 : 2'b00);
    rpi_read(3'd7, 8'h11);
    chk("tc_pending_ch1_cleared", tc_pending, IRQ ? 2'b01 : 2'b00);
    rpi_read(3'd3, 8'h22);
    chk("tc_pending_ch0_cleared", tc_pending, 0);
    chk("frame_err_clean", frame_err, 0);
    // With dsr_en low, TI accesses are ignored.
    dsr_en = 1'b0;
    cyc(4);
    ti_write(16'h5FFF, 8'h77);
    ti_a = 16'h5FF9; ti_memen = 1'b0; ti_dbin = 1'b1;
    lows = 0;
    repeat (10) begin cyc(1); if (!ti_dout_oe) lows++; end
    chk("oe_stays_high_dsr_off", lows, 0);
    ti_dbin = 1'b0; ti_memen = 1'b1; dsr_en = 1'b1;
    cyc(4);
    rpi_read(3'd2, 8'hA5);
    // Short frame: no write, sticky error; the next full frame works.
    rpi_write(3'd1, 8'h55, 7);
    chk("frame_err_short", frame_err, 1);
    ti_read(16'h5FF9, 8'h00);
    rpi_write(3'd1, 8'h5A, 8);
    ti_read(16'h5FF9, 8'h5A);
    chk("frame_err_sticky", frame_err, 1);
    // TC pending flag, then reset in the middle of a shift.
    ti_write(16'h5FFD, 8'h99);
    chk("tc_pending_set", tc_pending, IRQ ? 2'b01 : 2'b00);
    rpi_read(3'd3, 8'h99);
    chk("tc_pending_cleared", tc_pending, 0);
    tq.push_back(8'h3C);
    ti_a = 16'h5FFB; ti_memen = 1'b0; ti_dbin = 1'b1;
    rpi_regsel = 3'd2;
    cyc(2);
    sle_pulse();
    rq.push_back(1'b1);
    rq.push_back(1'b0);
    repeat (2) sclk_pulse();
    cyc(2);
    chk("sdata_out_mid_shift", rpi_sdata_out, 1);
    chk("oe_low_before_rst", ti_dout_oe, 0);
    rst = 1'b1;
    #2;
    chk("rst2_dout", ti_dout, 0);
    chk("rst2_oe", ti_dout_oe, 1);
    chk("rst2_sdata_out", rpi_sdata_out, 0);
    chk("rst2_frame_err", frame_err, 0);
    chk("rst2_tc_pending", tc_pending, 0);
    ti_dbin = 1'b0; ti_memen = 1'b1;
    cyc(3);
    rst = 1'b0;
    cyc(5);
    rpi_read(3'd2, 8'h00);
    ti_read(16'h5FFB, 8'h00);
    cyc(5);
    chk("queues_drained", tq.size() + rq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
